// File: rtl/multi_status_pkg.sv
// Shared constants for the multi-channel status register file.
// Register indices, ASHI response codes and handler state encoding.
package multi_status_pkg;

  localparam logic [6:0] REG_BUSY       = 7'd0;
  localparam logic [6:0] REG_LINK       = 7'd1;
  localparam logic [6:0] REG_BUSY_START = 7'd2;
  localparam logic [6:0] REG_LINK_LOST  = 7'd3;
  localparam logic [6:0] REG_IRQ_EN     = 7'd4;
  localparam logic [6:0] REG_CONTROL    = 7'd5;
  localparam logic [6:0] REG_COUNT_BASE = 7'd8;

  localparam logic [6:0] ADDR_MASK = 7'h7F;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } ashi_state_e;

  function automatic logic is_count_idx(input logic [6:0] idx, input int unsigned num_ch);
    logic [31:0] idx_w;
    logic [31:0] base_w;
    idx_w  = {25'd0, idx};
    base_w = {25'd0, REG_COUNT_BASE};
    return (idx_w >= base_w) && (idx_w < (base_w + num_ch));
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// One-bit synchroniser followed by a history flop and registered
// rise/fall pulses; everything clears on the synchronous reset.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchroniser chain, history flop and registered edge pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/multi_channel_status.sv
// Status/event register file for NUM_CH packet-generator channels, reached
// through the ASHI handler interface with separate write and read machines.
module multi_channel_status
  import multi_status_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] ch_link,
  output logic [NUM_CH-1:0] status_led,
  output logic              irq,
  input  logic              ashi_write,
  input  logic [31:0]       ashi_windx,
  input  logic [31:0]       ashi_wdata,
  output logic [1:0]        ashi_wresp,
  output logic              ashi_widle,
  input  logic              ashi_read,
  input  logic [31:0]       ashi_rindx,
  output logic [31:0]       ashi_rdata,
  output logic [1:0]        ashi_rresp,
  output logic              ashi_ridle
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [NUM_CH-1:0] busy_sync_s;
  logic [NUM_CH-1:0] busy_rise_s;
  logic [NUM_CH-1:0] busy_fall_unused_s;
  logic [NUM_CH-1:0] link_sync_s;
  logic [NUM_CH-1:0] link_rise_unused_s;
  logic [NUM_CH-1:0] link_fall_s;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_busy (
      .clk    (clk),
      .resetn (resetn),
      .async_i(ch_busy[ch]),
      .sync_o (busy_sync_s[ch]),
      .rise_o (busy_rise_s[ch]),
      .fall_o (busy_fall_unused_s[ch])
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_link (
      .clk    (clk),
      .resetn (resetn),
      .async_i(ch_link[ch]),
      .sync_o (link_sync_s[ch]),
      .rise_o (link_rise_unused_s[ch]),
      .fall_o (link_fall_s[ch])
    );
  end

  logic [NUM_CH-1:0] busy_start_q, busy_start_d;
  logic [NUM_CH-1:0] link_lost_q,  link_lost_d;
  logic [NUM_CH-1:0] irq_en_q,     irq_en_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              irq_q, irq_d;

  ashi_state_e wr_state_q, wr_state_d;
  ashi_state_e rd_state_q, rd_state_d;
  logic        wr_fire_s, rd_fire_s;
  logic        widle_s, ridle_s;

  logic [6:0]  widx_s, ridx_s;
  logic        widx_hi_s, ridx_hi_s;
  logic [1:0]  wr_resp_s;
  logic        wr_sel_bs_s, wr_sel_ll_s, wr_sel_en_s, wr_sel_ctl_s;
  logic [1:0]  wresp_q;
  logic [31:0] rd_data_s, rdata_q;
  logic [1:0]  rd_resp_s, rresp_q;

  logic [NUM_CH-1:0] bs_clr_s, ll_clr_s;
  logic              cnt_clr_s;
  logic              unused_wdata_s;

  // Anything above the 7-bit decoded index is treated as unmapped
  assign widx_s    = ashi_windx[6:0] & ADDR_MASK;
  assign widx_hi_s = |ashi_windx[31:7];
  assign ridx_s    = ashi_rindx[6:0] & ADDR_MASK;
  assign ridx_hi_s = |ashi_rindx[31:7];
  assign unused_wdata_s = &{1'b0, ashi_wdata};

  // Write machine: state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= ST_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  // Write machine: next state
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      ST_IDLE: begin
        if (ashi_write) begin
          wr_state_d = ST_RESP;
        end else begin
          wr_state_d = ST_IDLE;
        end
      end
      ST_RESP: wr_state_d = ST_IDLE;
      default: wr_state_d = ST_IDLE;
    endcase
  end

  // Write machine: outputs
  always_comb begin
    wr_fire_s = 1'b0;
    widle_s   = 1'b0;
    case (wr_state_q)
      ST_IDLE: begin
        wr_fire_s = ashi_write;
        widle_s   = ~ashi_write;
      end
      ST_RESP: begin
        wr_fire_s = 1'b0;
        widle_s   = 1'b0;
      end
      default: begin
        wr_fire_s = 1'b0;
        widle_s   = 1'b0;
      end
    endcase
  end

  // Write address decode and response selection
  always_comb begin
    wr_resp_s    = RESP_OKAY;
    wr_sel_bs_s  = 1'b0;
    wr_sel_ll_s  = 1'b0;
    wr_sel_en_s  = 1'b0;
    wr_sel_ctl_s = 1'b0;
    if (widx_hi_s) begin
      wr_resp_s = RESP_DECERR;
    end else begin
      case (widx_s)
        REG_BUSY, REG_LINK: wr_resp_s    = RESP_SLVERR;
        REG_BUSY_START:     wr_sel_bs_s  = 1'b1;
        REG_LINK_LOST:      wr_sel_ll_s  = 1'b1;
        REG_IRQ_EN:         wr_sel_en_s  = 1'b1;
        REG_CONTROL:        wr_sel_ctl_s = 1'b1;
        default: begin
          if (is_count_idx(widx_s, NUM_CH)) begin
            wr_resp_s = RESP_SLVERR;
          end else begin
            wr_resp_s = RESP_DECERR;
          end
        end
      endcase
    end
  end

  // New events OR in after the W1C mask so a coincident event is never lost
  always_comb begin
    bs_clr_s  = (wr_fire_s & wr_sel_bs_s) ? ashi_wdata[NUM_CH-1:0] : {NUM_CH{1'b0}};
    ll_clr_s  = (wr_fire_s & wr_sel_ll_s) ? ashi_wdata[NUM_CH-1:0] : {NUM_CH{1'b0}};
    cnt_clr_s = wr_fire_s & wr_sel_ctl_s & ashi_wdata[0];
    busy_start_d = (busy_start_q & ~bs_clr_s) | busy_rise_s;
    link_lost_d  = (link_lost_q & ~ll_clr_s) | link_fall_s;
    if (wr_fire_s & wr_sel_en_s) begin
      irq_en_d = ashi_wdata[NUM_CH-1:0];
    end else begin
      irq_en_d = irq_en_q;
    end
    irq_d = |(link_lost_q & irq_en_q);
  end

  // Saturating busy-start counters; a clear coinciding with an edge counts it
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (cnt_clr_s) begin
        cnt_d[ch] = busy_rise_s[ch] ? CNT_ONE : CNT_ZERO;
      end else if (busy_rise_s[ch] && (cnt_q[ch] != CNT_MAX)) begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end else begin
        cnt_d[ch] = cnt_q[ch];
      end
    end
  end

  // Event latches, interrupt mask, counters and interrupt output
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_start_q <= {NUM_CH{1'b0}};
      link_lost_q  <= {NUM_CH{1'b0}};
      irq_en_q     <= {NUM_CH{1'b0}};
      irq_q        <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= CNT_ZERO;
      end
    end else begin
      busy_start_q <= busy_start_d;
      link_lost_q  <= link_lost_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  // Write response register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wresp_q <= RESP_OKAY;
    end else if (wr_fire_s) begin
      wresp_q <= wr_resp_s;
    end else begin
      wresp_q <= wresp_q;
    end
  end

  // Read machine: state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= ST_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // Read machine: next state
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      ST_IDLE: begin
        if (ashi_read) begin
          rd_state_d = ST_RESP;
        end else begin
          rd_state_d = ST_IDLE;
        end
      end
      ST_RESP: rd_state_d = ST_IDLE;
      default: rd_state_d = ST_IDLE;
    endcase
  end

  // Read machine: outputs
  always_comb begin
    rd_fire_s = 1'b0;
    ridle_s   = 1'b0;
    case (rd_state_q)
      ST_IDLE: begin
        rd_fire_s = ashi_read;
        ridle_s   = ~ashi_read;
      end
      ST_RESP: begin
        rd_fire_s = 1'b0;
        ridle_s   = 1'b0;
      end
      default: begin
        rd_fire_s = 1'b0;
        ridle_s   = 1'b0;
      end
    endcase
  end

  // Read data mux; CONTROL is write-only and reads as zero
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    if (ridx_hi_s) begin
      rd_resp_s = RESP_DECERR;
    end else begin
      case (ridx_s)
        REG_BUSY:       rd_data_s = 32'(busy_sync_s);
        REG_LINK:       rd_data_s = 32'(link_sync_s);
        REG_BUSY_START: rd_data_s = 32'(busy_start_q);
        REG_LINK_LOST:  rd_data_s = 32'(link_lost_q);
        REG_IRQ_EN:     rd_data_s = 32'(irq_en_q);
        REG_CONTROL:    rd_data_s = 32'd0;
        default: begin
          if (is_count_idx(ridx_s, NUM_CH)) begin
            rd_resp_s = RESP_OKAY;
          end else begin
            rd_resp_s = RESP_DECERR;
          end
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if ({25'd0, ridx_s} == ({25'd0, REG_COUNT_BASE} + 32'(ch))) begin
              rd_data_s = 32'(cnt_q[ch]);
            end else begin
              rd_data_s = rd_data_s;
            end
          end
        end
      endcase
    end
  end

  // Read data and response registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (rd_fire_s) begin
      rdata_q <= rd_data_s;
      rresp_q <= rd_resp_s;
    end else begin
      rdata_q <= rdata_q;
      rresp_q <= rresp_q;
    end
  end

  assign status_led = busy_sync_s;
  assign irq        = irq_q;
  assign ashi_wresp = wresp_q;
  assign ashi_widle = widle_s;
  assign ashi_rdata = rdata_q;
  assign ashi_rresp = rresp_q;
  assign ashi_ridle = ridle_s;

endmodule

// File: tb/tb_multi_channel_status.sv
// Directed bench for multi_channel_status: a table of register accesses
// plus hand-timed sequences for edge timing, saturation and reset.
module tb_multi_channel_status;

  localparam int NUM_CH      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  logic              clk;
  logic              resetn;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_link;
  logic [NUM_CH-1:0] status_led;
  logic              irq;
  logic              ashi_write;
  logic [31:0]       ashi_windx;
  logic [31:0]       ashi_wdata;
  logic [1:0]        ashi_wresp;
  logic              ashi_widle;
  logic              ashi_read;
  logic [31:0]       ashi_rindx;
  logic [31:0]       ashi_rdata;
  logic [1:0]        ashi_rresp;
  logic              ashi_ridle;

  int total = 0;
  int bad   = 0;

  multi_channel_status #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .ch_busy(ch_busy), .ch_link(ch_link),
    .status_led(status_led), .irq(irq),
    .ashi_write(ashi_write), .ashi_windx(ashi_windx), .ashi_wdata(ashi_wdata),
    .ashi_wresp(ashi_wresp), .ashi_widle(ashi_widle),
    .ashi_read(ashi_read), .ashi_rindx(ashi_rindx), .ashi_rdata(ashi_rdata),
    .ashi_rresp(ashi_rresp), .ashi_ridle(ashi_ridle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] idx;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int N_VEC = 18;
  vec_t tbl [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_widle(input string name);
    int n = 0;
    while (!ashi_widle && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_widle"}, {31'd0, ashi_widle}, 32'd1);
  endtask

  task automatic wait_ridle(input string name);
    int n = 0;
    while (!ashi_ridle && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ridle"}, {31'd0, ashi_ridle}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the strobe edge unless waiting for idle
  task automatic ashi_wr(input logic [31:0] idx, input logic [31:0] data,
                         input logic [1:0] exp_resp, input string name, input bit skip_idle);
    ashi_windx = idx;
    ashi_wdata = data;
    ashi_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ashi_write = 1'b0;
    check({name, "_wresp"}, {30'd0, ashi_wresp}, {30'd0, exp_resp});
    if (!skip_idle) wait_widle(name);
  endtask

  task automatic ashi_rd(input logic [31:0] idx, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string name);
    ashi_rindx = idx;
    ashi_read  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ashi_read = 1'b0;
    check({name, "_rdata"}, ashi_rdata, exp_data);
    check({name, "_rresp"}, {30'd0, ashi_rresp}, {30'd0, exp_resp});
    wait_ridle(name);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'd0,  32'd0,          32'd0, OKAY};
    tbl[1]  = '{1'b0, 32'd1,  32'd0,          32'd0, OKAY};
    tbl[2]  = '{1'b0, 32'd2,  32'd0,          32'd0, OKAY};
    tbl[3]  = '{1'b0, 32'd3,  32'd0,          32'd0, OKAY};
    tbl[4]  = '{1'b0, 32'd4,  32'd0,          32'd0, OKAY};
    tbl[5]  = '{1'b0, 32'd5,  32'd0,          32'd0, OKAY};
    tbl[6]  = '{1'b0, 32'd8,  32'd0,          32'd0, OKAY};
    tbl[7]  = '{1'b0, 32'd9,  32'd0,          32'd0, OKAY};
    tbl[8]  = '{1'b0, 32'd7,  32'd0,          32'd0, DECERR};
    tbl[9]  = '{1'b0, 32'd10, 32'd0,          32'd0, DECERR};
    tbl[10] = '{1'b1, 32'd4,  32'hFFFF_FFFF,  32'd0, OKAY};
    tbl[11] = '{1'b0, 32'd4,  32'd0,          32'd3, OKAY};
    tbl[12] = '{1'b1, 32'd4,  32'd0,          32'd0, OKAY};
    tbl[13] = '{1'b1, 32'd9,  32'd1,          32'd0, SLVERR};
    tbl[14] = '{1'b1, 32'd31, 32'd0,          32'd0, DECERR};
    tbl[15] = '{1'b1, 32'd5,  32'd0,          32'd0, OKAY};
    tbl[16] = '{1'b0, 32'd6,  32'd0,          32'd0, DECERR};
    tbl[17] = '{1'b1, 32'd0,  32'd3,          32'd0, SLVERR};

    resetn = 1'b0;
    ch_busy = '0;
    ch_link = '0;
    ashi_write = 1'b0;
    ashi_read = 1'b0;
    ashi_windx = 32'd0;
    ashi_wdata = 32'd0;
    ashi_rindx = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state of outputs
    check("rst_widle", {31'd0, ashi_widle}, 32'd1);
    check("rst_ridle", {31'd0, ashi_ridle}, 32'd1);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("rst_led",   {30'd0, status_led}, 32'd0);
    check("rst_wresp", {30'd0, ashi_wresp}, 32'd0);
    check("rst_rresp", {30'd0, ashi_rresp}, 32'd0);
    check("rst_rdata", ashi_rdata, 32'd0);

    // Register map sweep
    for (int i = 0; i < N_VEC; i++) begin
      if (tbl[i].wr) begin
        ashi_wr(tbl[i].idx, tbl[i].wdata, tbl[i].exp_resp, $sformatf("vec%0d", i), 1'b0);
      end else begin
        ashi_rd(tbl[i].idx, tbl[i].exp_rdata, tbl[i].exp_resp, $sformatf("vec%0d", i));
      end
    end

    // Three busy pulses on channel 1
    for (int p = 0; p < 3; p++) begin
      ch_busy[1] = 1'b1;
      repeat (5) @(negedge clk);
      check($sformatf("led_p%0d", p), {30'd0, status_led}, 32'd2);
      repeat (5) @(negedge clk);
      ch_busy[1] = 1'b0;
      repeat (10) @(negedge clk);
    end
    ashi_rd(32'd2, 32'd2, OKAY, "bs_after3");
    ashi_rd(32'd9, 32'd3, OKAY, "cnt1_3");
    ashi_rd(32'd8, 32'd0, OKAY, "cnt0_0");
    ashi_wr(32'd2, 32'd2, OKAY, "bs_w1c", 1'b0);
    ashi_rd(32'd2, 32'd0, OKAY, "bs_clear");

    // Link up is not an event; link down raises irq after sync + edge + latch + irq flops
    ch_link[0] = 1'b1;
    repeat (6) @(negedge clk);
    ashi_rd(32'd1, 32'd1, OKAY, "link_up");
    ashi_rd(32'd3, 32'd0, OKAY, "ll_no_rise");
    ashi_wr(32'd4, 32'd1, OKAY, "en_w", 1'b0);
    ch_link[0] = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("irq_early", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, irq}, 32'd1);
    ashi_rd(32'd3, 32'd1, OKAY, "ll_set");
    ashi_wr(32'd3, 32'd1, OKAY, "ll_w1c", 1'b1);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_fall", {31'd0, irq}, 32'd0);
    ashi_rd(32'd3, 32'd0, OKAY, "ll_clear");

    // Twenty busy edges saturate a 4-bit counter at 15
    for (int p = 0; p < 20; p++) begin
      ch_busy[0] = 1'b1;
      repeat (4) @(negedge clk);
      ch_busy[0] = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    ashi_rd(32'd8, 32'd15, OKAY, "cnt0_sat");

    // Counter clear landing on the cycle the edge is applied keeps that edge
    ch_busy[0] = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    ashi_wr(32'd5, 32'd1, OKAY, "ctl_clr", 1'b0);
    ashi_rd(32'd8, 32'd1, OKAY, "cnt0_clr_edge");
    ashi_rd(32'd9, 32'd0, OKAY, "cnt1_clr");
    ch_busy[0] = 1'b0;
    repeat (6) @(negedge clk);

    // W1C on the same cycle as a new busy-start event: set wins
    ch_busy[1] = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    ashi_wr(32'd2, 32'd2, OKAY, "bs_setwins", 1'b0);
    ashi_rd(32'd2, 32'd3, OKAY, "bs_both");
    ashi_rd(32'd9, 32'd1, OKAY, "cnt1_1");
    ch_busy[1] = 1'b0;

    // RO write rejected and BUSY untouched
    ch_busy = 2'b01;
    repeat (6) @(negedge clk);
    ashi_wr(32'd0, 32'hFF, SLVERR, "ro_busy_w", 1'b0);
    ashi_rd(32'd0, 32'd1, OKAY, "busy_live");
    ashi_wr(32'd31, 32'd0, DECERR, "unmapped_w", 1'b0);
    ch_busy = 2'b00;
    repeat (6) @(negedge clk);

    // Reset while the write machine sits in RESP
    ashi_windx = 32'd4;
    ashi_wdata = 32'd3;
    ashi_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ashi_write = 1'b0;
    check("mid_busy", {31'd0, ashi_widle}, 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    check("rstmid_widle", {31'd0, ashi_widle}, 32'd1);
    check("rstmid_ridle", {31'd0, ashi_ridle}, 32'd1);
    check("rstmid_wresp", {30'd0, ashi_wresp}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rstmid_irq", {31'd0, irq}, 32'd0);
    ashi_rd(32'd2, 32'd0, OKAY, "rst_bs");
    ashi_rd(32'd3, 32'd0, OKAY, "rst_ll");
    ashi_rd(32'd4, 32'd0, OKAY, "rst_en");
    ashi_rd(32'd8, 32'd0, OKAY, "rst_cnt0");
    ashi_rd(32'd9, 32'd0, OKAY, "rst_cnt1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
